// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, EX redirect flushes and debug halt/single-step drain.
// Define HAZARD_PERF_CNT_EN to build the StallCnt/FlushCnt performance counters.

module pipeline_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idex_mem_read_i,
  input  logic [4:0]  idex_rt_i,
  input  logic [4:0]  ifid_rs_i,
  input  logic [4:0]  ifid_rt_i,
  input  logic        ifid_uses_rt_i,
  input  logic        redirect_i,
  input  logic        halt_req_i,
  input  logic        step_req_i,
  output logic        pc_write_en_o,
  output logic        ifid_write_en_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        halted_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam logic [2:0] ST_RUN     = 3'd0;
  localparam logic [2:0] ST_LDSTALL = 3'd1;
  localparam logic [2:0] ST_DRAIN   = 3'd2;
  localparam logic [2:0] ST_HALTED  = 3'd3;
  localparam logic [2:0] ST_STEP    = 3'd4;

  // The first stall cycle is spent in RUN, so LDSTALL only covers the remainder.
  localparam logic       STALL_MULTI = (LOAD_STALL_CYCLES > 1) ? 1'b1 : 1'b0;
  localparam logic [3:0] STALL_INIT  = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
  localparam logic [3:0] DRAIN_INIT  = 4'(DRAIN_CYCLES - 1);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       step_q;

  logic       lu_s;
  logic       step_rise_s;
  logic       pc_we_s;
  logic       ifid_we_s;
  logic       ifid_flush_s;
  logic       idex_bubble_s;
  logic       halted_s;

  // Load-use hazard detection between EX load and ID consumer.
  always_comb begin
    lu_s = idex_mem_read_i & (idex_rt_i != 5'd0) &
           ((idex_rt_i == ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)));
    step_rise_s = step_req_i & ~step_q;
  end

  // Next-state and raw output decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_we_s       = 1'b1;
    ifid_we_s     = 1'b1;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    halted_s      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (redirect_i) begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
          if (halt_req_i) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_INIT;
          end else begin
            state_d = ST_RUN;
          end
        end else if (lu_s) begin
          pc_we_s       = 1'b0;
          ifid_we_s     = 1'b0;
          idex_bubble_s = 1'b1;
          if (STALL_MULTI) begin
            state_d = ST_LDSTALL;
            cnt_d   = STALL_INIT;
          end else begin
            state_d = ST_RUN;
          end
        end else if (halt_req_i) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_INIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_LDSTALL: begin
        if (redirect_i) begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
          state_d       = ST_RUN;
        end else begin
          pc_we_s       = 1'b0;
          ifid_we_s     = 1'b0;
          idex_bubble_s = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (redirect_i) begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
        end else if (lu_s) begin
          pc_we_s       = 1'b0;
          ifid_we_s     = 1'b0;
          idex_bubble_s = 1'b1;
        end else begin
          pc_we_s       = 1'b0;
          ifid_flush_s  = 1'b1;
        end
        // A load-use pause freezes the drain count; a redirect does not.
        if (redirect_i || !lu_s) begin
          if (cnt_q == 4'd0) begin
            state_d = ST_HALTED;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_HALTED: begin
        pc_we_s       = 1'b0;
        ifid_we_s     = 1'b0;
        idex_bubble_s = 1'b1;
        halted_s      = 1'b1;
        if (!halt_req_i) begin
          state_d = ST_RUN;
        end else if (step_rise_s) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_HALTED;
        end
      end
      ST_STEP: begin
        if (redirect_i) begin
          ifid_flush_s  = 1'b1;
          idex_bubble_s = 1'b1;
        end else begin
          ifid_flush_s  = 1'b0;
        end
        state_d = ST_DRAIN;
        cnt_d   = DRAIN_INIT;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Reset forces the pipe into a safe flush/bubble condition immediately.
  always_comb begin
    if (!rst_n) begin
      pc_write_en_o   = 1'b0;
      ifid_write_en_o = 1'b0;
      ifid_flush_o    = 1'b1;
      idex_bubble_o   = 1'b1;
      halted_o        = 1'b0;
    end else begin
      pc_write_en_o   = pc_we_s;
      ifid_write_en_o = ifid_we_s;
      ifid_flush_o    = ifid_flush_s;
      idex_bubble_o   = idex_bubble_s;
      halted_o        = halted_s;
    end
  end

  // Sequencer state, counter and StepReq edge-detect flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_req_i;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Performance counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!pc_we_s && (state_q != ST_HALTED)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (redirect_i) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'h0;
  assign flush_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: two instances (default and LOAD_STALL_CYCLES=3,
// DRAIN_CYCLES=2) driven in lock-step and compared to a cycle-level behavioural model.

module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       rst_n;
    logic       mr;
    logic [4:0] rt;
    logic [4:0] rs;
    logic [4:0] rt2;
    logic       urt;
    logic       redir;
    logic       halt;
    logic       step;
  } stim_t;

  // Output vectors packed as {PC_WriteEn, IFID_WriteEn, IFID_Flush, IDEX_Bubble, Halted}.
  localparam logic [4:0] V_RST   = 5'b00110;
  localparam logic [4:0] V_DEF   = 5'b11000;
  localparam logic [4:0] V_STALL = 5'b00010;
  localparam logic [4:0] V_REDIR = 5'b11110;
  localparam logic [4:0] V_DRAIN = 5'b01100;
  localparam logic [4:0] V_HALT  = 5'b00011;

  localparam int M_RUN = 0, M_STALL = 1, M_DRAIN = 2, M_HALT = 3, M_STEP = 4;

  logic clk = 1'b0;
  logic rst_n, mr, urt, redir, halt, step;
  logic [4:0] rt_ex, rs_id, rt_id;

  logic pc0, we0, fl0, bb0, h0, pc1, we1, fl1, bb1, h1;
  logic [31:0] sc0, fc0, sc1, fc1;

  wire [4:0] obs0 = {pc0, we0, fl0, bb0, h0};
  wire [4:0] obs1 = {pc1, we1, fl1, bb1, h1};

  int checks = 0;
  int failures = 0;

  int         m_mode [2];
  int         m_left [2];
  int         n_mode [2];
  int         n_left [2];
  logic [4:0] exp_o  [2];
  logic [31:0] exp_sc [2];
  logic [31:0] exp_fc [2];
  logic [31:0] n_sc   [2];
  logic [31:0] n_fc   [2];
  logic       m_prev_step, n_prev_step;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .idex_mem_read_i(mr), .idex_rt_i(rt_ex), .ifid_rs_i(rs_id), .ifid_rt_i(rt_id),
    .ifid_uses_rt_i(urt), .redirect_i(redir), .halt_req_i(halt), .step_req_i(step),
    .pc_write_en_o(pc0), .ifid_write_en_o(we0), .ifid_flush_o(fl0), .idex_bubble_o(bb0),
    .halted_o(h0), .stall_cnt_o(sc0), .flush_cnt_o(fc0)
  );

  pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .DRAIN_CYCLES(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .idex_mem_read_i(mr), .idex_rt_i(rt_ex), .ifid_rs_i(rs_id), .ifid_rt_i(rt_id),
    .ifid_uses_rt_i(urt), .redirect_i(redir), .halt_req_i(halt), .step_req_i(step),
    .pc_write_en_o(pc1), .ifid_write_en_o(we1), .ifid_flush_o(fl1), .idex_bubble_o(bb1),
    .halted_o(h1), .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  always #5 clk = ~clk;

  function automatic int p_l(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int p_d(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic logic [4:0] obs_of(int i);
    return (i == 0) ? obs0 : obs1;
  endfunction

  function automatic logic [31:0] sc_of(int i);
    return (i == 0) ? sc0 : sc1;
  endfunction

  function automatic logic [31:0] fc_of(int i);
    return (i == 0) ? fc0 : fc1;
  endfunction

  function automatic logic [31:0] want_sc(int i);
`ifdef HAZARD_PERF_CNT_EN
    return exp_sc[i];
`else
    return 32'h0;
`endif
  endfunction

  function automatic logic [31:0] want_fc(int i);
`ifdef HAZARD_PERF_CNT_EN
    return exp_fc[i];
`else
    return 32'h0;
`endif
  endfunction

  function automatic stim_t s_idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_lu(logic [4:0] r, logic [4:0] src);
    stim_t s;
    s = s_idle();
    s.mr = 1'b1;
    s.rt = r;
    s.rs = src;
    return s;
  endfunction

  function automatic stim_t s_rst();
    stim_t s;
    s = s_idle();
    s.rst_n = 1'b0;
    return s;
  endfunction

  // Behavioural model: spec rules with "cycles remaining" bookkeeping.
  task automatic eval_model();
    bit lu;
    lu = mr && (rt_ex != 5'd0) && ((rt_ex == rs_id) || (urt && (rt_ex == rt_id)));
    for (int i = 0; i < 2; i++) begin
      n_mode[i] = m_mode[i];
      n_left[i] = m_left[i];
      if (!rst_n) begin
        exp_o[i] = V_RST;
        exp_sc[i] = 32'd0;
        exp_fc[i] = 32'd0;
        n_mode[i] = M_RUN;
        n_left[i] = 0;
      end else begin
        case (m_mode[i])
          M_RUN: begin
            if (redir) begin
              exp_o[i] = V_REDIR;
              if (halt) begin n_mode[i] = M_DRAIN; n_left[i] = p_d(i); end
            end else if (lu) begin
              exp_o[i] = V_STALL;
              if (p_l(i) > 1) begin n_mode[i] = M_STALL; n_left[i] = p_l(i) - 1; end
            end else begin
              exp_o[i] = V_DEF;
              if (halt) begin n_mode[i] = M_DRAIN; n_left[i] = p_d(i); end
            end
          end
          M_STALL: begin
            if (redir) begin
              exp_o[i] = V_REDIR;
              n_mode[i] = M_RUN;
            end else begin
              exp_o[i] = V_STALL;
              n_left[i] = m_left[i] - 1;
              if (n_left[i] == 0) n_mode[i] = M_RUN;
            end
          end
          M_DRAIN: begin
            if (!redir && lu) begin
              exp_o[i] = V_STALL;
            end else begin
              exp_o[i] = redir ? V_REDIR : V_DRAIN;
              n_left[i] = m_left[i] - 1;
              if (n_left[i] == 0) n_mode[i] = M_HALT;
            end
          end
          M_HALT: begin
            exp_o[i] = V_HALT;
            if (!halt) n_mode[i] = M_RUN;
            else if (step && !m_prev_step) n_mode[i] = M_STEP;
          end
          default: begin
            exp_o[i] = redir ? V_REDIR : V_DEF;
            n_mode[i] = M_DRAIN;
            n_left[i] = p_d(i);
          end
        endcase
      end
      n_sc[i] = (!rst_n) ? 32'd0 :
                exp_sc[i] + ((exp_o[i][4] == 1'b0 && m_mode[i] != M_HALT) ? 32'd1 : 32'd0);
      n_fc[i] = (!rst_n) ? 32'd0 : exp_fc[i] + (redir ? 32'd1 : 32'd0);
    end
    n_prev_step = rst_n ? step : 1'b0;
  endtask

  task automatic apply(input stim_t s);
    rst_n = s.rst_n; mr = s.mr; rt_ex = s.rt; rs_id = s.rs; rt_id = s.rt2;
    urt = s.urt; redir = s.redir; halt = s.halt; step = s.step;
    eval_model();
    #3;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = n_mode[i];
      m_left[i] = n_left[i];
      exp_sc[i] = n_sc[i];
      exp_fc[i] = n_fc[i];
    end
    m_prev_step = n_prev_step;
  endtask

  task automatic test_reset();
    stim_t s;
    s = s_rst();
    s.redir = 1'b1; s.halt = 1'b1; s.mr = 1'b1; s.rt = 5'd3; s.rs = 5'd3;
    apply(s);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_of(i) !== V_RST) begin
        $display("FAIL reset inst%0d outputs got=%b want=%b", i, obs_of(i), V_RST);
        failures++;
      end
      checks++;
      if (sc_of(i) !== 32'd0 || fc_of(i) !== 32'd0) begin
        $display("FAIL reset_cnt inst%0d got=%0d/%0d want=0/0", i, sc_of(i), fc_of(i));
        failures++;
      end
    end
    advance();
    apply(s_idle());
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_of(i) !== V_DEF) begin
        $display("FAIL reset_release inst%0d got=%b want=%b", i, obs_of(i), V_DEF);
        failures++;
      end
    end
    advance();
  endtask

  task automatic test_load_use();
    stim_t q[$];
    stim_t s;
    q.push_back(s_rst()); q.push_back(s_idle());
    q.push_back(s_lu(5'd5, 5'd5));
    for (int j = 0; j < 4; j++) q.push_back(s_idle());
    q.push_back(s_lu(5'd0, 5'd0));
    q.push_back(s_idle());
    s = s_lu(5'd7, 5'd3); s.rt2 = 5'd7; q.push_back(s);
    s.urt = 1'b1; q.push_back(s);
    for (int j = 0; j < 4; j++) q.push_back(s_idle());
    foreach (q[k]) begin
      apply(q[k]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_o[i]) begin
          $display("FAIL load_use[%0d] inst%0d got=%b want=%b", k, i, obs_of(i), exp_o[i]);
          failures++;
        end
      end
      if (k == 2 || k == 10) begin
        checks++;
        if (obs0 !== V_STALL) begin
          $display("FAIL load_use_stall[%0d] got=%b want=%b", k, obs0, V_STALL);
          failures++;
        end
      end else if (k == 3 || k == 7 || k == 9) begin
        checks++;
        if (obs0 !== V_DEF) begin
          $display("FAIL load_use_nostall[%0d] got=%b want=%b", k, obs0, V_DEF);
          failures++;
        end
      end
      advance();
    end
  endtask

  task automatic test_load_stall3();
    stim_t q[$];
    int n0, n1, first1, last1;
    n0 = 0; n1 = 0; first1 = -1; last1 = -1;
    q.push_back(s_rst()); q.push_back(s_idle());
    q.push_back(s_lu(5'd9, 5'd9));
    for (int j = 0; j < 6; j++) q.push_back(s_idle());
    foreach (q[k]) begin
      apply(q[k]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_o[i]) begin
          $display("FAIL stall3[%0d] inst%0d got=%b want=%b", k, i, obs_of(i), exp_o[i]);
          failures++;
        end
      end
      if (k >= 2 && pc0 === 1'b0) n0++;
      if (k >= 2 && pc1 === 1'b0) begin
        n1++;
        if (first1 < 0) first1 = k;
        last1 = k;
      end
      advance();
    end
    checks++;
    if (n1 != 3 || (last1 - first1) != 2) begin
      $display("FAIL stall3_count got=%0d span=%0d want=3 span=2", n1, last1 - first1);
      failures++;
    end
    checks++;
    if (n0 != 1) begin
      $display("FAIL stall1_count got=%0d want=1", n0);
      failures++;
    end
  endtask

  task automatic test_redirect();
    stim_t q[$];
    stim_t s;
    q.push_back(s_rst()); q.push_back(s_idle());
    s = s_lu(5'd4, 5'd4); s.redir = 1'b1; q.push_back(s);
    q.push_back(s_idle()); q.push_back(s_idle());
    q.push_back(s_lu(5'd6, 5'd6));
    s = s_idle(); s.redir = 1'b1; q.push_back(s);
    q.push_back(s_idle()); q.push_back(s_idle());
    s = s_idle(); s.redir = 1'b1; s.halt = 1'b1; q.push_back(s);
    s.redir = 1'b0;
    for (int j = 0; j < 6; j++) q.push_back(s);
    for (int j = 0; j < 3; j++) q.push_back(s_idle());
    foreach (q[k]) begin
      apply(q[k]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_o[i]) begin
          $display("FAIL redirect[%0d] inst%0d got=%b want=%b", k, i, obs_of(i), exp_o[i]);
          failures++;
        end
      end
      if (k == 2 || k == 9) begin
        checks++;
        if (obs0 !== V_REDIR || obs1 !== V_REDIR) begin
          $display("FAIL redirect_win[%0d] got=%b/%b want=%b", k, obs0, obs1, V_REDIR);
          failures++;
        end
      end else if (k == 3) begin
        checks++;
        if (obs0 !== V_DEF || obs1 !== V_DEF) begin
          $display("FAIL redirect_nostall got=%b/%b want=%b", obs0, obs1, V_DEF);
          failures++;
        end
      end else if (k == 10) begin
        checks++;
        if (obs0 !== V_DRAIN) begin
          $display("FAIL redirect_halt_drain got=%b want=%b", obs0, V_DRAIN);
          failures++;
        end
      end
      advance();
    end
  endtask

  task automatic test_halt_drain();
    stim_t q[$];
    stim_t s;
    logic [4:0] want0 [19];
    want0 = '{V_RST, V_DEF, V_DEF, V_DRAIN, V_DRAIN, V_DRAIN, V_DRAIN, V_HALT, V_HALT, V_HALT,
              V_HALT, V_DEF, V_DEF, V_DRAIN, V_DRAIN, V_DRAIN, V_DRAIN, V_HALT, V_DEF};
    q.push_back(s_rst()); q.push_back(s_idle());
    s = s_idle(); s.halt = 1'b1;
    for (int j = 0; j < 6; j++) q.push_back(s);
    s.redir = 1'b1; q.push_back(s);
    s.redir = 1'b0; q.push_back(s);
    q.push_back(s_idle()); q.push_back(s_idle());
    q.push_back(s);
    for (int j = 0; j < 6; j++) q.push_back(s_idle());
    foreach (q[k]) begin
      apply(q[k]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_o[i]) begin
          $display("FAIL halt[%0d] inst%0d got=%b want=%b", k, i, obs_of(i), exp_o[i]);
          failures++;
        end
      end
      if (k < 19) begin
        checks++;
        if (obs0 !== want0[k]) begin
          $display("FAIL halt_seq[%0d] got=%b want=%b", k, obs0, want0[k]);
          failures++;
        end
      end
      advance();
    end
  endtask

  task automatic test_step();
    stim_t q[$];
    stim_t s;
    int pcs;
    pcs = 0;
    q.push_back(s_rst()); q.push_back(s_idle());
    s = s_idle(); s.halt = 1'b1;
    for (int j = 0; j < 7; j++) q.push_back(s);
    s.step = 1'b1;
    for (int j = 0; j < 11; j++) q.push_back(s);
    q.push_back(s_idle()); q.push_back(s_idle());
    foreach (q[k]) begin
      apply(q[k]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_o[i]) begin
          $display("FAIL step[%0d] inst%0d got=%b want=%b", k, i, obs_of(i), exp_o[i]);
          failures++;
        end
      end
      if (k >= 9 && k <= 19 && pc0 === 1'b1) pcs++;
      if (k == 15) begin
        checks++;
        if (obs0 !== V_HALT) begin
          $display("FAIL step_rehalt got=%b want=%b", obs0, V_HALT);
          failures++;
        end
      end
      advance();
    end
    checks++;
    if (pcs != 1) begin
      $display("FAIL step_once fetches=%0d want=1", pcs);
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    stim_t q[$];
    stim_t s;
    q.push_back(s_rst()); q.push_back(s_idle());
    q.push_back(s_lu(5'd2, 5'd2));
    s = s_lu(5'd2, 5'd2); s.rst_n = 1'b0; q.push_back(s);
    s = s_idle(); s.redir = 1'b1; q.push_back(s);
    s = s_idle(); s.halt = 1'b1; q.push_back(s); q.push_back(s);
    s.rst_n = 1'b0; q.push_back(s);
    q.push_back(s_idle()); q.push_back(s_idle());
    foreach (q[k]) begin
      apply(q[k]);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_o[i]) begin
          $display("FAIL reset_mid[%0d] inst%0d got=%b want=%b", k, i, obs_of(i), exp_o[i]);
          failures++;
        end
        checks++;
        if (sc_of(i) !== want_sc(i) || fc_of(i) !== want_fc(i)) begin
          $display("FAIL reset_mid_cnt[%0d] inst%0d got=%0d/%0d want=%0d/%0d",
                   k, i, sc_of(i), fc_of(i), want_sc(i), want_fc(i));
          failures++;
        end
      end
      if (k == 3 || k == 7) begin
        checks++;
        if (obs0 !== V_RST || obs1 !== V_RST) begin
          $display("FAIL reset_mid_force[%0d] got=%b/%b want=%b", k, obs0, obs1, V_RST);
          failures++;
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    stim_t s;
    logic hl, sl;
    hl = 1'b0; sl = 1'b0;
    apply(s_rst());
    advance();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) hl = ~hl;
      if ($urandom_range(0, 2) == 0) sl = ~sl;
      s = s_idle();
      s.mr    = ($urandom_range(0, 2) == 0);
      s.rt    = 5'($urandom_range(0, 3));
      s.rs    = 5'($urandom_range(0, 3));
      s.rt2   = 5'($urandom_range(0, 3));
      s.urt   = 1'($urandom_range(0, 1));
      s.redir = ($urandom_range(0, 7) == 0);
      s.halt  = hl;
      s.step  = sl;
      s.rst_n = ($urandom_range(0, 199) != 0);
      apply(s);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_of(i) !== exp_o[i]) begin
          $display("FAIL random[%0d] inst%0d got=%b want=%b", k, i, obs_of(i), exp_o[i]);
          failures++;
        end
        checks++;
        if (sc_of(i) !== want_sc(i) || fc_of(i) !== want_fc(i)) begin
          $display("FAIL random_cnt[%0d] inst%0d got=%0d/%0d want=%0d/%0d",
                   k, i, sc_of(i), fc_of(i), want_sc(i), want_fc(i));
          failures++;
        end
      end
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = M_RUN; m_left[i] = 0; exp_sc[i] = 32'd0; exp_fc[i] = 32'd0;
    end
    m_prev_step = 1'b0;
    rst_n = 1'b0; mr = 1'b0; urt = 1'b0; redir = 1'b0; halt = 1'b0; step = 1'b0;
    rt_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_load_stall3();
    test_redirect();
    test_halt_drain();
    test_step();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
